csr_access_arb: RTL and testbench

CSR_ACCESS_ARB -- requirements
Module: csr_access_arb

---
 rtl/csr_access_arb_if.sv | 38 +++
 rtl/csr_access_arb.sv | 72 +++++++
 tb/tb_csr_access_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_arb_if.sv
// csr_access_arb_if: pipeline, debug and supervisor-CSR signals shared by the arbiter.
interface csr_access_arb_if #(parameter int XLEN = 64);
    logic            PipeCSRReqM;
    logic            PipeCSRWriteM;
    logic [11:0]     PipeCSRAdrM;
    logic [XLEN-1:0] PipeCSRWriteValM;
    logic            STrapM;
    logic            StallPipeM;
    logic            DbgReqValid;
    logic            DbgReqReady;
    logic            DbgWrite;
    logic            DbgWide;
    logic [11:0]     DbgAdr;
    logic [63:0]     DbgWData;
    logic            DbgRspValid;
    logic            DbgRspReady;
    logic [XLEN-1:0] DbgRspData;
    logic            DbgRspErr;
    logic            CSRSWriteM;
    logic [11:0]     CSRAdrM;
    logic [XLEN-1:0] CSRWriteValM;
    logic [XLEN-1:0] CSRSReadValM;
    logic            IllegalCSRSAccessM;
    modport master (
        input  PipeCSRReqM, PipeCSRWriteM, PipeCSRAdrM, PipeCSRWriteValM, STrapM,
        input  DbgReqValid, DbgWrite, DbgWide, DbgAdr, DbgWData, DbgRspReady,
        input  CSRSReadValM, IllegalCSRSAccessM,
        output StallPipeM, DbgReqReady, DbgRspValid, DbgRspData, DbgRspErr,
        output CSRSWriteM, CSRAdrM, CSRWriteValM
    );
    modport slave (
        output PipeCSRReqM, PipeCSRWriteM, PipeCSRAdrM, PipeCSRWriteValM, STrapM,
        output DbgReqValid, DbgWrite, DbgWide, DbgAdr, DbgWData, DbgRspReady,
        output CSRSReadValM, IllegalCSRSAccessM,
        input  StallPipeM, DbgReqReady, DbgRspValid, DbgRspData, DbgRspErr,
        input  CSRSWriteM, CSRAdrM, CSRWriteValM
    );
endinterface

// File: rtl/csr_access_arb.sv
// csr_access_arb: shares the supervisor CSR port between the M-stage pipeline and a debug requester.
module csr_access_arb #(
    parameter int XLEN    = 64,
    parameter int MAXWAIT = 8
) (
    input logic              clk,
    input logic              reset,
    csr_access_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACC, HI, RSP} state_e;
    state_e          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic            write_q, write_d, wide_q, wide_d, err_q, err_d;
    logic [11:0]     adr_q, adr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            dbg_acc, dbg_hi, accept, legal, go_hi;
    always_comb begin
        // Debug ownership is masked during reset so a reset in HI never writes the high word.
        dbg_acc          = (state_q == ACC) & ~reset;
        dbg_hi           = (state_q == HI) & ~reset;
        legal            = ~bus.IllegalCSRSAccessM & ~bus.STrapM;
        bus.DbgReqReady  = (state_q == IDLE) & ~reset & ~bus.STrapM
                         & (~bus.PipeCSRReqM | (wait_q == 4'(MAXWAIT)));
        accept           = bus.DbgReqValid & bus.DbgReqReady;
        bus.StallPipeM   = (dbg_acc | dbg_hi) & bus.PipeCSRReqM;
        bus.CSRAdrM      = dbg_acc ? adr_q : dbg_hi ? 12'h15D : bus.PipeCSRAdrM;
        bus.CSRWriteValM = dbg_acc ? wdata_q[XLEN-1:0] : dbg_hi ? XLEN'(wdata_q[63:32]) : bus.PipeCSRWriteValM;
        bus.CSRSWriteM   = dbg_acc ? write_q & legal : dbg_hi ? legal : bus.PipeCSRReqM & bus.PipeCSRWriteM;
        bus.DbgRspValid  = (state_q == RSP) & ~reset;
        bus.DbgRspData   = rdata_q;
        bus.DbgRspErr    = err_q;
        go_hi            = (XLEN == 32) & wide_q & write_q & (adr_q == 12'h14D) & ~bus.IllegalCSRSAccessM;
        wait_d           = (accept | ~bus.DbgReqValid) ? 4'd0
                         : ((state_q == IDLE) & (wait_q != 4'(MAXWAIT))) ? wait_q + 4'd1 : wait_q;
        write_d          = accept ? bus.DbgWrite : write_q;
        wide_d           = accept ? bus.DbgWide : wide_q;
        adr_d            = accept ? bus.DbgAdr : adr_q;
        wdata_d          = accept ? bus.DbgWData : wdata_q;
        rdata_d          = (dbg_acc & ~bus.STrapM) ? bus.CSRSReadValM : rdata_q;
        err_d            = (dbg_acc & ~bus.STrapM) ? bus.IllegalCSRSAccessM
                         : (dbg_hi & ~bus.STrapM) ? err_q | bus.IllegalCSRSAccessM : err_q;
        state_d          = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ACC : IDLE;
            ACC:     state_d = bus.STrapM ? ACC : go_hi ? HI : RSP;
            HI:      state_d = bus.STrapM ? HI : RSP;
            default: state_d = bus.DbgRspReady ? IDLE : RSP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_csr_access_arb.sv
// tb_csr_access_arb: vector table, directed corner sequences and a randomized run against a transaction model.
module tb_csr_access_arb;
    localparam int XLEN = 32;
    localparam int MAXWAIT = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    csr_access_arb_if #(.XLEN(XLEN)) bus();
    csr_access_arb #(.XLEN(XLEN), .MAXWAIT(MAXWAIT)) dut (.clk(clk), .reset(reset), .bus(bus));
    // Supervisor CSR block stand-in: 0x180 is the only illegal address.
    logic [31:0] mem [4096];
    logic [31:0] ref_mem [4096];
    logic        tb_we = 1'b0;
    logic [11:0] tb_wa = '0;
    logic [31:0] tb_wd = '0;
    assign bus.IllegalCSRSAccessM = (bus.CSRAdrM == 12'h180);
    assign bus.CSRSReadValM = bus.IllegalCSRSAccessM ? 32'h0 : mem[bus.CSRAdrM];
    always @(posedge clk)
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (bus.CSRSWriteM) mem[bus.CSRAdrM] <= bus.CSRWriteValM;
    int tests = 0;
    int fails = 0;
    logic [11:0] addrs [6] = '{12'h140, 12'h141, 12'h14D, 12'h15D, 12'h180, 12'h142};
    typedef struct packed {
        logic        req;
        logic        wr;
        logic [11:0] adr;
        logic [31:0] val;
        logic        strap;
        logic        exp_ready;
        logic        exp_we;
    } vec_t;
    vec_t tbl [6];
    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;
    rsp_t exp_q [$];
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs;
        bus.PipeCSRReqM = 0; bus.PipeCSRWriteM = 0; bus.PipeCSRAdrM = '0; bus.PipeCSRWriteValM = '0;
        bus.STrapM = 0; bus.DbgReqValid = 0; bus.DbgWrite = 0; bus.DbgWide = 0;
        bus.DbgAdr = '0; bus.DbgWData = '0; bus.DbgRspReady = 0;
    endtask
    task automatic dbg_req(input logic w, input logic wide, input logic [11:0] a, input logic [63:0] d);
        bus.DbgReqValid = 1; bus.DbgWrite = w; bus.DbgWide = wide; bus.DbgAdr = a; bus.DbgWData = d;
    endtask
    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        tb_we = 1; tb_wa = a; tb_wd = d; ref_mem[a] = d;
        tick();
        tb_we = 0;
    endtask
    task automatic finish_rsp;
        bus.DbgRspReady = 1;
        tick();
        bus.DbgRspReady = 0;
    endtask
    initial begin
        int n;
        int stuck;
        logic acc_now;
        logic il;
        rsp_t r;
        idle_inputs();
        for (int i = 0; i < 6; i++) poke(addrs[i], 32'hC500_0000 | 32'(addrs[i]));
        // Reset state
        dbg_req(0, 0, 12'h140, 64'h0);
        @(negedge clk);
        chk("rst_ready", bus.DbgReqReady, 0);
        chk("rst_stall", bus.StallPipeM, 0);
        chk("rst_rspvalid", bus.DbgRspValid, 0);
        tick();
        reset = 0;
        bus.DbgReqValid = 0;
        @(negedge clk);
        chk("rst_rspdata", bus.DbgRspData, 0);
        chk("rst_rsperr", bus.DbgRspErr, 0);
        chk("rst_rspvalid2", bus.DbgRspValid, 0);
        tick();
        // Pipeline ownership and ready rule in IDLE
        tbl = '{
            '{1'b0, 1'b0, 12'h100, 32'h1, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 12'h101, 32'h2, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 12'h102, 32'h3, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 12'h103, 32'h4, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 12'h104, 32'h5, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 12'h105, 32'h6, 1'b1, 1'b0, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            bus.PipeCSRReqM = tbl[i].req; bus.PipeCSRWriteM = tbl[i].wr;
            bus.PipeCSRAdrM = tbl[i].adr; bus.PipeCSRWriteValM = tbl[i].val; bus.STrapM = tbl[i].strap;
            @(negedge clk);
            chk("tbl_ready", bus.DbgReqReady, tbl[i].exp_ready);
            chk("tbl_we", bus.CSRSWriteM, tbl[i].exp_we);
            chk("tbl_adr", bus.CSRAdrM, tbl[i].adr);
            chk("tbl_val", bus.CSRWriteValM, tbl[i].val);
            chk("tbl_stall", bus.StallPipeM, 0);
            tick();
        end
        idle_inputs();
        // Plain debug read, idle pipeline
        poke(12'h140, 32'h1234);
        dbg_req(0, 0, 12'h140, 64'h0);
        @(negedge clk);
        chk("rd_ready_c0", bus.DbgReqReady, 1);
        chk("rd_stall_c0", bus.StallPipeM, 0);
        tick();
        bus.DbgReqValid = 0;
        @(negedge clk);
        chk("rd_acc_adr", bus.CSRAdrM, 12'h140);
        chk("rd_acc_we", bus.CSRSWriteM, 0);
        chk("rd_acc_stall", bus.StallPipeM, 0);
        chk("rd_acc_rspvalid", bus.DbgRspValid, 0);
        tick();
        @(negedge clk);
        chk("rd_rspvalid_c2", bus.DbgRspValid, 1);
        chk("rd_rspdata", bus.DbgRspData, 32'h1234);
        chk("rd_rsperr", bus.DbgRspErr, 0);
        finish_rsp();
        // Starvation bound under a busy pipeline
        bus.PipeCSRReqM = 1; bus.PipeCSRAdrM = 12'h101;
        dbg_req(0, 0, 12'h141, 64'h0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.DbgReqReady) break;
            n++;
            tick();
        end
        chk("starve_blocked_cycles", 64'(n), 8);
        chk("starve_stall_accept", bus.StallPipeM, 0);
        tick();
        bus.DbgReqValid = 0;
        @(negedge clk);
        chk("starve_stall_acc", bus.StallPipeM, 1);
        tick();
        @(negedge clk);
        chk("starve_stall_rsp", bus.StallPipeM, 0);
        chk("starve_rspdata", bus.DbgRspData, ref_mem[12'h141]);
        finish_rsp();
        idle_inputs();
        // Wide STIMECMP write on RV32
        dbg_req(1, 1, 12'h14D, 64'h00000001_80000000);
        @(negedge clk);
        chk("wide_ready", bus.DbgReqReady, 1);
        tick();
        bus.DbgReqValid = 0; bus.PipeCSRReqM = 1;
        @(negedge clk);
        chk("wide_lo_we", bus.CSRSWriteM, 1);
        chk("wide_lo_adr", bus.CSRAdrM, 12'h14D);
        chk("wide_lo_val", bus.CSRWriteValM, 32'h80000000);
        chk("wide_lo_stall", bus.StallPipeM, 1);
        tick();
        @(negedge clk);
        chk("wide_hi_we", bus.CSRSWriteM, 1);
        chk("wide_hi_adr", bus.CSRAdrM, 12'h15D);
        chk("wide_hi_val", bus.CSRWriteValM, 32'h1);
        chk("wide_hi_stall", bus.StallPipeM, 1);
        tick();
        @(negedge clk);
        chk("wide_rspvalid", bus.DbgRspValid, 1);
        chk("wide_rsperr", bus.DbgRspErr, 0);
        chk("wide_rspdata", bus.DbgRspData, ref_mem[12'h14D]);
        ref_mem[12'h14D] = 32'h80000000;
        ref_mem[12'h15D] = 32'h1;
        finish_rsp();
        idle_inputs();
        // Trap during ACC retries the write
        dbg_req(1, 0, 12'h141, 64'h0000_0000_DEAD_BEEF);
        tick();
        bus.DbgReqValid = 0; bus.STrapM = 1;
        @(negedge clk);
        chk("trap_we", bus.CSRSWriteM, 0);
        chk("trap_adr", bus.CSRAdrM, 12'h141);
        tick();
        bus.STrapM = 0;
        @(negedge clk);
        chk("trap_retry_we", bus.CSRSWriteM, 1);
        chk("trap_retry_val", bus.CSRWriteValM, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("trap_rspvalid", bus.DbgRspValid, 1);
        ref_mem[12'h141] = 32'hDEADBEEF;
        finish_rsp();
        // Illegal address
        dbg_req(0, 0, 12'h180, 64'h0);
        tick();
        bus.DbgReqValid = 0;
        tick();
        @(negedge clk);
        chk("ill_rd_rspvalid", bus.DbgRspValid, 1);
        chk("ill_rd_err", bus.DbgRspErr, 1);
        chk("ill_rd_data", bus.DbgRspData, 0);
        finish_rsp();
        dbg_req(1, 1, 12'h180, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        bus.DbgReqValid = 0;
        @(negedge clk);
        chk("ill_wr_we", bus.CSRSWriteM, 0);
        tick();
        @(negedge clk);
        chk("ill_wr_no_hi", bus.DbgRspValid, 1);
        chk("ill_wr_err", bus.DbgRspErr, 1);
        finish_rsp();
        // Reset while in HI
        dbg_req(1, 1, 12'h14D, 64'h00000002_00000003);
        tick();
        bus.DbgReqValid = 0;
        tick();
        reset = 1;
        @(negedge clk);
        chk("hi_reset_we", bus.CSRSWriteM, 0);
        tick();
        reset = 0;
        ref_mem[12'h14D] = 32'h3;
        @(negedge clk);
        chk("hi_reset_rspvalid", bus.DbgRspValid, 0);
        chk("hi_reset_ready", bus.DbgReqReady, 1);
        chk("hi_reset_rspdata", bus.DbgRspData, 0);
        tick();
        // Randomized traffic against the transaction model
        stuck = 0;
        acc_now = 0;
        for (int c = 0; c < 3000; c++) begin
            if (acc_now) bus.DbgReqValid = 0;
            acc_now = 0;
            if (!bus.DbgReqValid && $urandom_range(0, 2) == 0)
                dbg_req(1'($urandom), 1'($urandom), addrs[$urandom_range(0, 5)], {$urandom, $urandom});
            bus.PipeCSRReqM = 1'($urandom);
            bus.PipeCSRWriteM = 1'($urandom);
            bus.PipeCSRAdrM = 12'h100 + 12'($urandom_range(0, 15));
            bus.PipeCSRWriteValM = $urandom;
            bus.STrapM = ($urandom_range(0, 4) == 0);
            bus.DbgRspReady = 1'($urandom);
            @(negedge clk);
            stuck++;
            if (bus.DbgReqValid && bus.DbgReqReady) begin
                il = (bus.DbgAdr == 12'h180);
                r.d = il ? 32'h0 : ref_mem[bus.DbgAdr];
                r.e = il;
                if (bus.DbgWrite && !il) begin
                    ref_mem[bus.DbgAdr] = bus.DbgWData[31:0];
                    if (bus.DbgWide && bus.DbgAdr == 12'h14D) ref_mem[12'h15D] = bus.DbgWData[63:32];
                end
                exp_q.push_back(r);
                acc_now = 1;
                stuck = 0;
            end
            if (bus.DbgRspValid && bus.DbgRspReady) begin
                stuck = 0;
                if (exp_q.size() == 0) chk("rand_unexpected_rsp", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("rand_rspdata", bus.DbgRspData, r.d);
                    chk("rand_rsperr", bus.DbgRspErr, r.e);
                end
            end
            if (stuck > 200) begin
                chk("rand_progress_timeout", 64'(stuck), 0);
                break;
            end
            tick();
        end
        if (acc_now) bus.DbgReqValid = 0;
        bus.DbgReqValid = 0; bus.PipeCSRReqM = 0; bus.STrapM = 0; bus.DbgRspReady = 1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (bus.DbgRspValid) begin
                r = exp_q.pop_front();
                chk("drain_rspdata", bus.DbgRspData, r.d);
                chk("drain_rsperr", bus.DbgRspErr, r.e);
            end
            tick();
        end
        chk("drain_outstanding", 64'(exp_q.size()), 0);
        tick();
        for (int i = 0; i < 6; i++) chk($sformatf("mem_%0h", addrs[i]), mem[addrs[i]], ref_mem[addrs[i]]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
